pairing_scheduler: RTL and testbench

PAIRING_SCHEDULER -- requirements
Module: pairing_scheduler

---
 rtl/pairing_scheduler_pkg.sv | 21 ++
 rtl/inc.v | 7 +
 rtl/pairing_rr_arb2.sv | 23 ++
 rtl/pairing_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_pairing_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pairing_scheduler_pkg.sv
// rtl/pairing_scheduler_pkg.sv - FSM encoding and counter widths for the pairing scheduler
//
// Contents:
//   state_e      scheduler FSM states
//   START_CNT_W  width of the core-reset (START) down-counter
//   RUN_CNT_W    width of the RUN cycle counter (covers TIMEOUT_CYC up to 65535)
//   JOBS_W       width of the completed-jobs counter
package pairing_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int START_CNT_W = 4;
  localparam int RUN_CNT_W   = 16;
  localparam int JOBS_W      = 16;

endpackage

// File: rtl/inc.v
// rtl/inc.v - shared operand width macros for the pairing core and its scheduler
`ifndef PAIRING_INC_V
`define PAIRING_INC_V
// Coordinate operands are `WIDTH+1 bits; the pairing result is `W6+1 bits.
`define WIDTH 7
`define W6 47
`endif

// File: rtl/pairing_rr_arb2.sv
// rtl/pairing_rr_arb2.sv - two-way round-robin grant logic
//
// Ports:
//   req_i   [1:0]  request vector
//   prio_i         preferred requester when both request
//   gnt_o   [1:0]  one-hot grant (zero when nothing requests)
module pairing_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = prio_i ? 2'b10 : 2'b01;
    end else begin
      // Zero or one requester: the grant is the request itself.
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/pairing_scheduler.sv
// rtl/pairing_scheduler.sv - round-robin job scheduler in front of one shared tate_pairing core
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]   per-requester job handshake (req_ready combinational, IDLE only)
//   req_x1/y1/x2/y2             per-requester operands, slice k belongs to requester k
//   core_reset                  active-high reset to the core, low only while the job runs
//   core_x1/y1/x2/y2            operands latched at accept, stable until the next accept
//   core_done, core_out         core completion flag and result
//   rsp_valid/rsp_ready         response handshake
//   rsp_id, rsp_err, rsp_data   owning requester, timeout flag, result
//   busy                        high whenever a job is in flight
//   jobs_done [15:0]            wrapping count of delivered responses
`include "inc.v"
module pairing_scheduler
  import pairing_scheduler_pkg::*;
#(
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [2*(`WIDTH+1)-1:0]  req_x1,
  input  logic [2*(`WIDTH+1)-1:0]  req_y1,
  input  logic [2*(`WIDTH+1)-1:0]  req_x2,
  input  logic [2*(`WIDTH+1)-1:0]  req_y2,
  output logic                     core_reset,
  output logic [`WIDTH:0]          core_x1,
  output logic [`WIDTH:0]          core_y1,
  output logic [`WIDTH:0]          core_x2,
  output logic [`WIDTH:0]          core_y2,
  input  logic                     core_done,
  input  logic [`W6:0]             core_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic                     rsp_err,
  output logic [`W6:0]             rsp_data,
  output logic                     busy,
  output logic [JOBS_W-1:0]        jobs_done
);

  localparam int OPW = `WIDTH + 1;
  localparam logic [START_CNT_W-1:0] START_LOAD = START_CNT_W'(RST_CYC);
  // Last RUN count before abort; unused when the timeout is disabled.
  localparam logic [RUN_CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYC == 0) ? '0 : RUN_CNT_W'(TIMEOUT_CYC - 1);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  state_e                 state_q, state_d;
  logic                   prio_q, prio_d;
  logic [START_CNT_W-1:0] start_cnt_q, start_cnt_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [OPW-1:0]         x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic                   rsp_id_q, rsp_id_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [`W6:0]           rsp_data_q, rsp_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   busy_q, busy_d;
  logic                   core_reset_q, core_reset_d;
  logic [JOBS_W-1:0]      jobs_q, jobs_d;

  logic [1:0] gnt;
  logic       winner;
  logic       in_idle;

  assign in_idle = (state_q == ST_IDLE);

  pairing_rr_arb2 u_arb (
    .req_i  (req_valid),
    .prio_i (prio_q),
    .gnt_o  (gnt)
  );

  // Grant is only offered while idle; there is no request queue.
  assign req_ready = in_idle ? gnt : 2'b00;
  assign winner    = gnt[1];

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    start_cnt_d = start_cnt_q;
    run_cnt_d   = run_cnt_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    x2_d        = x2_q;
    y2_d        = y2_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    jobs_d      = jobs_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          x1_d        = winner ? req_x1[2*OPW-1:OPW] : req_x1[OPW-1:0];
          y1_d        = winner ? req_y1[2*OPW-1:OPW] : req_y1[OPW-1:0];
          x2_d        = winner ? req_x2[2*OPW-1:OPW] : req_x2[OPW-1:0];
          y2_d        = winner ? req_y2[2*OPW-1:OPW] : req_y2[OPW-1:0];
          rsp_id_d    = winner;
          prio_d      = ~winner;
          start_cnt_d = START_LOAD;
          state_d     = ST_START;
        end
      end

      ST_START: begin
        // The counter was loaded with RST_CYC at accept, so leaving when it
        // reads 1 keeps core_reset high for exactly RST_CYC cycles here.
        if (start_cnt_q <= START_CNT_W'(1)) begin
          start_cnt_d = '0;
          run_cnt_d   = '0;
          state_d     = ST_RUN;
        end else begin
          start_cnt_d = start_cnt_q - START_CNT_W'(1);
        end
      end

      ST_RUN: begin
        run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
        // Completion has priority over a coincident timeout.
        if (core_done) begin
          rsp_data_d = core_out;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (TO_EN && (run_cnt_q == TO_LAST)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          jobs_d  = jobs_q + JOBS_W'(1);
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state register rather than lagging it by a cycle.
    rsp_valid_d  = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
    core_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      start_cnt_q  <= '0;
      run_cnt_q    <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      core_reset_q <= 1'b1;
      jobs_q       <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      start_cnt_q  <= start_cnt_d;
      run_cnt_q    <= run_cnt_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      x2_q         <= x2_d;
      y2_q         <= y2_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      core_reset_q <= core_reset_d;
      jobs_q       <= jobs_d;
    end
  end

  // Named handle kept separate so the completed-jobs register is easy to find.
  logic [JOBS_W-1:0] jobs_done_q;
  assign jobs_done_q = jobs_q;

  assign core_x1    = x1_q;
  assign core_y1    = y1_q;
  assign core_x2    = x2_q;
  assign core_y2    = y2_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = busy_q;
  assign core_reset = core_reset_q;
  assign jobs_done  = jobs_done_q;

endmodule

// File: tb/tb_pairing_scheduler.sv
// tb/tb_pairing_scheduler.sv - self-checking bench for pairing_scheduler with a stub core
`include "inc.v"
module tb_pairing_scheduler;

  localparam int RST = 2;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_x1, req_y1, req_x2, req_y2;
  logic        core_reset;
  logic [7:0]  core_x1, core_y1, core_x2, core_y2;
  logic        core_done;
  logic [47:0] core_out;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [47:0] rsp_data;
  logic        busy;
  logic [15:0] jobs_done;

  always #5 clk = ~clk;

  pairing_scheduler #(.RST_CYC(RST), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_y1(req_y1), .req_x2(req_x2), .req_y2(req_y2),
    .core_reset(core_reset),
    .core_x1(core_x1), .core_y1(core_y1), .core_x2(core_x2), .core_y2(core_y2),
    .core_done(core_done), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .busy(busy), .jobs_done(jobs_done)
  );

  // Stub core: done on RUN cycle stub_lat-1 (0 = never), result derived from its operands.
  int stub_lat;
  int run_idx = 0;
  always @(posedge clk) run_idx <= core_reset ? 0 : run_idx + 1;
  assign core_done = !core_reset && (stub_lat != 0) && (run_idx == stub_lat - 1);
  assign core_out  = {16'hA5C3, core_x1, core_y1, core_x2, core_y2};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // A job accepted on edge k holds core_reset through edge k+RST, runs until
  // min(stub latency, timeout) RUN cycles have elapsed, then offers its
  // response until the first edge on which rsp_ready is high.
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m_job, m_prio, m_id, m_err;
  logic [7:0]  m_x1, m_y1, m_x2, m_y2;
  logic [47:0] m_data;
  int          m_start, m_resp_edge;
  logic [15:0] m_hs;
  logic [15:0] bias = 16'h0;

  logic        m_gw, m_done_path;
  int          m_end;
  logic [7:0]  w_x1, w_y1, w_x2, w_y2;
  assign m_gw        = (req_valid == 2'b11) ? m_prio : req_valid[1];
  assign m_done_path = (stub_lat != 0) && (stub_lat <= TO);
  assign m_end       = m_done_path ? stub_lat - 1 : TO - 1;
  assign w_x1 = m_gw ? req_x1[15:8] : req_x1[7:0];
  assign w_y1 = m_gw ? req_y1[15:8] : req_y1[7:0];
  assign w_x2 = m_gw ? req_x2[15:8] : req_x2[7:0];
  assign w_y2 = m_gw ? req_y2[15:8] : req_y2[7:0];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_job <= 1'b0; m_prio <= 1'b0; m_hs <= 16'h0;
      m_id <= 1'b0; m_err <= 1'b0; m_data <= 48'h0;
      m_x1 <= 8'h0; m_y1 <= 8'h0; m_x2 <= 8'h0; m_y2 <= 8'h0;
      m_start <= 0; m_resp_edge <= 0;
    end else if (m_job) begin
      if (cyc >= m_resp_edge && rsp_ready) begin
        m_job <= 1'b0;
        m_hs  <= m_hs + 16'h1;
      end
    end else if (req_valid != 2'b00) begin
      m_job  <= 1'b1;
      m_id   <= m_gw;
      m_prio <= ~m_gw;
      m_x1 <= w_x1; m_y1 <= w_y1; m_x2 <= w_x2; m_y2 <= w_y2;
      m_err  <= !m_done_path;
      m_data <= m_done_path ? {16'hA5C3, w_x1, w_y1, w_x2, w_y2} : 48'h0;
      m_start     <= cyc + 1;
      m_resp_edge <= cyc + 1 + RST + m_end + 1;
    end
  end

  logic [1:0]  exp_rr;
  logic        exp_rv, exp_cr;
  logic [15:0] exp_jobs;
  assign exp_rr   = m_job ? 2'b00 :
                    (req_valid == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : req_valid;
  assign exp_rv   = m_job && (cyc >= m_resp_edge);
  assign exp_cr   = !(m_job && (cyc >= m_start + RST) && (cyc < m_resp_edge));
  assign exp_jobs = m_hs + bias;

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_job);
      chk("req_ready", req_ready, exp_rr);
      chk("core_reset", core_reset, exp_cr);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("core_ops", {core_x1, core_y1, core_x2, core_y2}, {m_x1, m_y1, m_x2, m_y2});
      chk("jobs_done", jobs_done, exp_jobs);
      if (exp_rv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_data", rsp_data, m_data);
      end
    end
  end

  // Monotonic activity counters; the stimulus compares snapshots.
  int rr0_cnt = 0, st_cnt = 0, rn_cnt = 0;
  always @(negedge clk) begin
    if (req_ready[0]) rr0_cnt <= rr0_cnt + 1;
    if (busy && !rsp_valid) begin
      if (core_reset) st_cnt <= st_cnt + 1;
      else            rn_cnt <= rn_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_accept();
    int n = 0;
    step();
    while (!busy && n < 20) begin step(); n++; end
    chk("accept_wait", busy, 1);
  endtask

  task automatic wait_rsp(input int bound);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < bound) begin @(negedge clk); n++; end
    chk("rsp_wait", rsp_valid, 1);
  endtask

  task automatic finish_hs();
    @(posedge clk); @(negedge clk);
  endtask

  int s_rr, s_st, s_rn;
  logic [1:0] cont_ids [4];

  initial begin
    reset = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1; stub_lat = 10;
    req_x1 = {8'h11, 8'h01}; req_y1 = {8'h12, 8'h02};
    req_x2 = {8'h13, 8'h03}; req_y2 = {8'h14, 8'h04};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_core_reset", core_reset, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_jobs", jobs_done, 0);
    chk("reset_ops", {core_x1, core_y1, core_x2, core_y2}, 32'h0);
    chk_en = 1'b1;
    step(); reset = 1'b1;
    step();

    // Single job from requester 0.
    s_rr = rr0_cnt; s_st = st_cnt; s_rn = rn_cnt;
    req_valid = 2'b01;
    wait_accept();
    req_valid = 2'b00;
    wait_rsp(100);
    chk("single_data", rsp_data, 48'hA5C3_0102_0304);
    chk("single_id", rsp_id, 0);
    chk("single_err", rsp_err, 0);
    finish_hs();
    chk("single_jobs", jobs_done, 1);
    chk("single_ready_pulses", rr0_cnt - s_rr, 1);
    chk("single_reset_cycles", st_cnt - s_st, RST);
    chk("single_run_cycles", rn_cnt - s_rn, 10);

    // Lone requester 1 wins even though prio points at it anyway; leaves prio=0.
    step();
    req_valid = 2'b10;
    wait_accept();
    req_valid = 2'b00;
    wait_rsp(100);
    chk("lone1_id", rsp_id, 1);
    chk("lone1_data", rsp_data, 48'hA5C3_1112_1314);
    finish_hs();

    // Contention: both valid for four back-to-back jobs.
    cont_ids = '{2'd0, 2'd1, 2'd0, 2'd1};
    step();
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(100);
      chk("cont_id", {1'b0, rsp_id}, cont_ids[i]);
    end
    req_valid = 2'b00;
    finish_hs();
    chk("cont_jobs", jobs_done, 6);

    // Backpressure: response held for 5 cycles with requester 0 still asking.
    step();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    wait_accept();
    s_rr = rr0_cnt;
    wait_rsp(100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_jobs", jobs_done, 6);
    end
    chk("bp_no_ready", rr0_cnt - s_rr, 0);
    step();
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    finish_hs();
    chk("bp_jobs_after", jobs_done, 7);

    // Timeout: core never finishes.
    step();
    stub_lat = 0;
    s_rn = rn_cnt;
    req_valid = 2'b01;
    wait_accept();
    req_valid = 2'b00;
    wait_rsp(100);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 48'h0);
    finish_hs();
    chk("to_run_cycles", rn_cnt - s_rn, TO);

    // Done on the final allowed cycle beats the timeout.
    step();
    stub_lat = TO;
    s_rn = rn_cnt;
    req_valid = 2'b01;
    wait_accept();
    req_valid = 2'b00;
    wait_rsp(100);
    chk("edge_err", rsp_err, 0);
    chk("edge_data", rsp_data, 48'hA5C3_0102_0304);
    finish_hs();
    chk("edge_run_cycles", rn_cnt - s_rn, TO);
    chk("edge_jobs", jobs_done, 9);

    // Reset during RUN cycle 5.
    stub_lat = 10;
    step();
    req_valid = 2'b10;
    wait_accept();
    req_valid = 2'b00;
    begin
      int n = 0;
      @(negedge clk);
      while (core_reset && n < 20) begin @(negedge clk); n++; end
      chk("run_reached", core_reset, 0);
    end
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_jobs", jobs_done, 0);
    step();
    reset = 1'b1;
    repeat (15) @(negedge clk);
    step();
    req_valid = 2'b11;
    wait_accept();
    req_valid = 2'b00;
    wait_rsp(100);
    chk("postrst_id", rsp_id, 0);
    chk("postrst_data", rsp_data, 48'hA5C3_0102_0304);
    finish_hs();
    chk("postrst_jobs", jobs_done, 1);

    // Counter wrap from 0xFFFF.
    step();
    force dut.jobs_done_q = 16'hFFFF;
    force dut.jobs_q = 16'hFFFF;
    bias = 16'hFFFF - m_hs;
    @(negedge clk);
    chk("wrap_preload", jobs_done, 16'hFFFF);
    step();
    release dut.jobs_q;
    release dut.jobs_done_q;
    req_valid = 2'b10;
    wait_accept();
    req_valid = 2'b00;
    wait_rsp(100);
    finish_hs();
    chk("wrap_jobs", jobs_done, 16'h0000);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
